// File: rtl/ff_fifo_reader.sv
// ff_fifo_reader: drains a push/pop FIFO into a registered valid/ready stream.
// A head/skid pair gives one word per cycle under continuous down_ready and
// absorbs one extra word when the consumer stalls.
// Optional statistics counters: define FF_FIFO_READER_STATS_EN to build them.
//
// Handshake: a word moves downstream on every rising edge where down_valid
// and down_ready are both 1. down_valid and down_data come straight from
// registers, and down_data holds while down_valid=1 and down_ready=0.
module ff_fifo_reader #(
  parameter int width      = 8,
  parameter int stat_width = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [width-1:0]      fifo_read_data,
  output logic                  fifo_pop,
  output logic                  down_valid,
  input  logic                  down_ready,
  output logic [width-1:0]      down_data,
  output logic [stat_width-1:0] word_count,
  output logic [stat_width-1:0] stall_count,
  output logic [1:0]            dbg_occ
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  occ_t             r_occ;
  occ_t             w_occ_nxt;
  logic [width-1:0] r_head;
  logic [width-1:0] r_skid;
  logic             w_pop;
  logic             w_xfer;
  logic             w_head_ld_fifo;
  logic             w_head_ld_skid;
  logic             w_skid_ld;

  // Pop only when there is room; rst_n gates it so no pop leaks out during reset.
  assign w_pop      = rst_n & ~fifo_empty & (r_occ != OCC_TWO);
  assign w_xfer     = (r_occ != OCC_EMPTY) & down_ready;
  assign fifo_pop   = w_pop;
  assign down_valid = (r_occ != OCC_EMPTY);
  assign down_data  = r_head;
  assign dbg_occ    = r_occ;

  // Occupancy state register; reset discards any buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_occ <= OCC_EMPTY;
    else        r_occ <= w_occ_nxt;
  end

  // Next occupancy and datapath load selects.
  always_comb begin
    w_occ_nxt      = r_occ;
    w_head_ld_fifo = 1'b0;
    w_head_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    case (r_occ)
      OCC_EMPTY: begin
        if (w_pop) begin
          w_head_ld_fifo = 1'b1;
          w_occ_nxt      = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (w_pop && !w_xfer) begin
          w_skid_ld = 1'b1;
          w_occ_nxt = OCC_TWO;
        end else if (w_pop && w_xfer) begin
          w_head_ld_fifo = 1'b1;
        end else if (w_xfer) begin
          w_occ_nxt = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // The skid word always drains before anything new is popped.
        if (w_xfer) begin
          w_head_ld_skid = 1'b1;
          w_occ_nxt      = OCC_ONE;
        end
      end
      default: w_occ_nxt = OCC_EMPTY;
    endcase
  end

  // Data registers carry no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (w_head_ld_fifo)      r_head <= fifo_read_data;
    else if (w_head_ld_skid) r_head <= r_skid;
    if (w_skid_ld)           r_skid <= fifo_read_data;
  end

`ifdef FF_FIFO_READER_STATS_EN
  localparam logic [stat_width-1:0] STAT_ONE = {{(stat_width-1){1'b0}}, 1'b1};

  logic [stat_width-1:0] r_word_count;
  logic [stat_width-1:0] r_stall_count;

  // Saturating delivery and backpressure counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_count  <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_xfer && !(&r_word_count))
        r_word_count <= r_word_count + STAT_ONE;
      if (down_valid && !down_ready && !(&r_stall_count))
        r_stall_count <= r_stall_count + STAT_ONE;
    end
  end

  assign word_count  = r_word_count;
  assign stall_count = r_stall_count;
`else
  assign word_count  = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_ff_fifo_reader.sv
// tb_ff_fifo_reader: directed and random checks of the FIFO drain stage
// against a simple array-backed FIFO model and an expected-word queue.
module tb_ff_fifo_reader;

  localparam int W  = 8;
  localparam int SW = 4;

  logic          clk;
  logic          rst_n;
  logic          fifo_empty;
  logic [W-1:0]  fifo_read_data;
  logic          fifo_pop;
  logic          down_valid;
  logic          down_ready;
  logic [W-1:0]  down_data;
  logic [SW-1:0] word_count;
  logic [SW-1:0] stall_count;
  logic [1:0]    dbg_occ;

  int checks = 0;
  int errors = 0;

  // FIFO model: words written by tasks, popped by the DUT.
  logic [W-1:0]  fifo_mem [0:4095];
  logic [11:0]   wr_ptr = '0;
  logic [11:0]   rd_ptr = '0;
  logic [W-1:0]  exp_q [$];

  assign fifo_empty     = (wr_ptr == rd_ptr);
  assign fifo_read_data = fifo_mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_pop) rd_ptr <= rd_ptr + 12'd1;
  end

  ff_fifo_reader #(.width(W), .stat_width(SW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_pop       (fifo_pop),
    .down_valid     (down_valid),
    .down_ready     (down_ready),
    .down_data      (down_data),
    .word_count     (word_count),
    .stall_count    (stall_count),
    .dbg_occ        (dbg_occ)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic push_word(input logic [W-1:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 12'd1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    down_ready = 1'b0;
    wr_ptr     = rd_ptr;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    down_ready = 1'b0;
    wr_ptr     = rd_ptr;
    repeat (2) @(negedge clk);
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", down_valid); end
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop got %b exp 0", fifo_pop); end
    checks++; if (word_count !== 4'd0) begin errors++; $display("FAIL reset_wc got %0d exp 0", word_count); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL reset_sc got %0d exp 0", stall_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_burst();
    logic [W-1:0] exp_w [3];
    exp_w = '{8'h11, 8'h22, 8'h33};
    apply_reset();
    down_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_word(exp_w[i]);
    #1;
    checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL burst_pop0 got %b exp 1", fifo_pop); end
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL burst_valid0 got %b exp 0", down_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (down_valid !== 1'b1) begin errors++; $display("FAIL burst_valid[%0d] got %b exp 1", i, down_valid); end
      checks++; if (down_data !== exp_w[i]) begin errors++; $display("FAIL burst_data[%0d] got %h exp %h", i, down_data, exp_w[i]); end
      checks++; if (fifo_pop !== (i < 2)) begin errors++; $display("FAIL burst_pop[%0d] got %b exp %b", i, fifo_pop, (i < 2)); end
    end
    @(negedge clk);
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL burst_valid_end got %b exp 0", down_valid); end
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL burst_pop_end got %b exp 0", fifo_pop); end
`ifdef FF_FIFO_READER_STATS_EN
    checks++; if (word_count !== 4'd3) begin errors++; $display("FAIL burst_wc got %0d exp 3", word_count); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL burst_sc got %0d exp 0", stall_count); end
`endif
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_w [3];
    exp_w = '{8'h11, 8'h22, 8'h33};
    apply_reset();
    down_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(exp_w[i]);
    #1;
    checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL bp_pop0 got %b exp 1", fifo_pop); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (down_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got %b exp 1", k, down_valid); end
      checks++; if (down_data !== 8'h11) begin errors++; $display("FAIL bp_hold_data[%0d] got %h exp 11", k, down_data); end
      checks++; if (fifo_pop !== (k == 0)) begin errors++; $display("FAIL bp_hold_pop[%0d] got %b exp %b", k, fifo_pop, (k == 0)); end
    end
    checks++; if (dbg_occ !== 2'd2) begin errors++; $display("FAIL bp_occ got %0d exp 2", dbg_occ); end
`ifdef FF_FIFO_READER_STATS_EN
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL bp_sc_mid got %0d exp 2", stall_count); end
`endif
    down_ready = 1'b1;
    #1;
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL bp_pop_release got %b exp 0", fifo_pop); end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      checks++; if (down_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, down_valid); end
      checks++; if (down_data !== exp_w[i]) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, down_data, exp_w[i]); end
      checks++; if (fifo_pop !== (i == 1)) begin errors++; $display("FAIL bp_pop[%0d] got %b exp %b", i, fifo_pop, (i == 1)); end
    end
    @(negedge clk);
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_end got %b exp 0", down_valid); end
`ifdef FF_FIFO_READER_STATS_EN
    checks++; if (word_count !== 4'd3) begin errors++; $display("FAIL bp_wc got %0d exp 3", word_count); end
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL bp_sc got %0d exp 2", stall_count); end
`endif
  endtask

  task automatic test_empty();
    apply_reset();
    down_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL empty_pop[%0d] got %b exp 0", i, fifo_pop); end
      checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL empty_valid[%0d] got %b exp 0", i, down_valid); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    apply_reset();
    for (int i = 0; i < 1000; i++) begin
      d = W'($urandom_range(0, 255));
      push_word(d);
      exp_q.push_back(d);
    end
    for (int cyc = 0; cyc < 5000; cyc++) begin
      down_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (down_valid && down_ready) begin
        checks++;
        if (down_data !== exp_q[0]) begin
          errors++;
          $display("FAIL rand_data[%0d] got %h exp %h", 1000 - exp_q.size(), down_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain got %0d left exp 0", exp_q.size()); end
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL rand_valid_end got %b exp 0", down_valid); end
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL rand_pop_end got %b exp 0", fifo_pop); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    down_ready = 1'b0;
    push_word(8'h44);
    push_word(8'h55);
    push_word(8'h66);
    repeat (2) @(negedge clk);
    checks++; if (dbg_occ !== 2'd2) begin errors++; $display("FAIL rmid_occ got %0d exp 2", dbg_occ); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", down_valid); end
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL rmid_pop got %b exp 0", fifo_pop); end
    @(negedge clk);
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL rmid_pop_held got %b exp 0", fifo_pop); end
    rst_n      = 1'b1;
    down_ready = 1'b1;
    #1;
    checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL rmid_pop_after got %b exp 1", fifo_pop); end
    @(negedge clk);
    checks++; if (down_valid !== 1'b1) begin errors++; $display("FAIL rmid_valid_after got %b exp 1", down_valid); end
    checks++; if (down_data !== 8'h66) begin errors++; $display("FAIL rmid_data got %h exp 66", down_data); end
    @(negedge clk);
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid_end got %b exp 0", down_valid); end
  endtask

  task automatic test_stats();
    apply_reset();
    down_ready = 1'b0;
    for (int i = 0; i < 20; i++) push_word(W'(i + 1));
    repeat (4) @(negedge clk);
`ifdef FF_FIFO_READER_STATS_EN
    checks++; if (word_count !== 4'd0) begin errors++; $display("FAIL stats_wc_mid got %0d exp 0", word_count); end
    checks++; if (stall_count !== 4'd3) begin errors++; $display("FAIL stats_sc_mid got %0d exp 3", stall_count); end
`endif
    down_ready = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL stats_valid_end got %b exp 0", down_valid); end
`ifdef FF_FIFO_READER_STATS_EN
    checks++; if (word_count !== 4'd15) begin errors++; $display("FAIL stats_wc got %0d exp 15", word_count); end
    checks++; if (stall_count !== 4'd3) begin errors++; $display("FAIL stats_sc got %0d exp 3", stall_count); end
`else
    checks++; if (word_count !== 4'd0) begin errors++; $display("FAIL stats_wc_off got %0d exp 0", word_count); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL stats_sc_off got %0d exp 0", stall_count); end
`endif
  endtask

  // Test sequence and final report
  initial begin
    rst_n      = 1'b0;
    down_ready = 1'b0;
    test_reset();
    test_burst();
    test_backpressure();
    test_empty();
    test_random();
    test_reset_mid();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_fifo_reader.md
# ff_fifo_reader

Drain stage for the team's push/pop FIFOs. It watches the FIFO's `empty` flag and its combinational `read_data`, issues `pop`, and presents the popped words on a registered valid/ready stream. A two-entry output buffer gives one word per cycle under continuous `down_ready`, and keeps `down_valid` and `down_data` glitch-free and register-driven. It sits between a FIFO instance (it drives the FIFO's `pop`) and any downstream consumer that can apply backpressure.

## Interface
- `width`, 8: data word width in bits.
- `stat_width`, 16: width of the optional statistics counters.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_read_data`  in  `width`  FIFO head word; valid whenever `fifo_empty` is 0.
- `fifo_pop`  out  1  pop request to the FIFO; a pop completes on each rising edge where it is 1.
- `down_valid`  out  1  `down_data` holds a word.
- `down_ready`  in  1  consumer accepts the word this cycle.
- `down_data`  out  `width`  head word of the output buffer.
- `word_count`  out  `stat_width`  words delivered downstream (see Configuration).
- `stall_count`  out  `stat_width`  backpressure cycles (see Configuration).

## Operation
- Storage: `head` and `skid` registers, each `width` bits, plus a 2-bit occupancy `occ` with states EMPTY=0, ONE=1, TWO=2. The value 3 is unreachable.
- Output decode:
  - `down_valid` = (`occ` != 0).
  - `down_data` = `head`.
- Pop: `fifo_pop` = `rst_n` & !`fifo_empty` & (`occ` != TWO).
  - This is combinational on registered `occ` and the `fifo_empty` input.
  - It is forced to 0 while `rst_n` is low.
- Transfer: `xfer` = `down_valid` & `down_ready`.
- State transitions, as (`occ`, `fifo_pop`, `xfer`) -> action:
  - EMPTY, pop: `head` <= `fifo_read_data`; -> ONE.
  - ONE, pop, no xfer: `skid` <= `fifo_read_data`; -> TWO.
  - ONE, pop, xfer: `head` <= `fifo_read_data`; stay ONE.
  - ONE, no pop, xfer: -> EMPTY.
  - TWO, xfer: `head` <= `skid`; -> ONE. No pop is possible in TWO.
  - All other combinations hold state.
- Ordering: words leave in strict pop order. No word is duplicated or dropped.
- `down_data` stays stable while `down_valid` is 1 and `down_ready` is 0.

## Timing
- Reset values: `occ`=EMPTY, `down_valid`=0, `fifo_pop`=0, `word_count`=0, `stall_count`=0.
  - `head` and `skid` are not reset; `down_data` is don't-care while `down_valid` is 0.
- Latency: a word popped at edge N is visible on `down_data` with `down_valid`=1 in cycle N+1. A non-empty FIFO therefore reaches the output after 1 cycle.
- Throughput: 1 word/cycle with `down_ready` held at 1 (steady state ONE, pop and transfer together every cycle).
- Backpressure:
  - With `down_ready`=0 the block accepts at most 2 words, then drops `fifo_pop` to 0.
  - When `down_ready` returns, the skid word drains first; popping resumes the cycle `occ` leaves TWO.
- FIFO empty: `fifo_pop` is 0 and the buffer drains normally.
- Reset mid-operation: buffered words are discarded and `down_valid` falls immediately, asynchronously with `rst_n`. Words already popped from the FIFO are lost; upstream owns recovery.
- The consumer may assert `down_ready` with `down_valid`=0; this has no effect.

## Configuration
- Macro: `FF_FIFO_READER_STATS_EN`.
- Defined:
  - `word_count` increments on every `xfer`.
  - `stall_count` increments on every cycle with `down_valid`=1 and `down_ready`=0.
  - Both counters saturate at all-ones and never wrap.
- Undefined: both outputs are tied to 0 and the counter registers are not built. Datapath behaviour is identical in both builds.

## Test plan
- Reset, then a FIFO holding 3 words 0x11, 0x22, 0x33, `down_ready`=1:
  - `fifo_pop` is 1 for 3 consecutive cycles.
  - `down_data` shows 0x11, 0x22, 0x33 in cycles 1–3 after the first pop, with `down_valid`=1 throughout; then `down_valid`=0.
- Same 3 words, `down_ready`=0:
  - `fifo_pop` is 1 for exactly 2 cycles, then 0.
  - `down_data`=0x11 holds.
  - Raising `down_ready` gives 0x11, 0x22, 0x33 in consecutive cycles with no gap.
- FIFO stays empty for 10 cycles: `fifo_pop`=0 and `down_valid`=0 throughout.
- Random `down_ready` (50%) over a 1000-word stream: the output sequence equals the input sequence exactly.
- Assert `rst_n`=0 while `occ`=TWO:
  - `down_valid` and `fifo_pop` go to 0 immediately.
  - After release, the next FIFO word appears 1 cycle after its pop.
- With `FF_FIFO_READER_STATS_EN` and `stat_width`=4: after 20 transfers `word_count`=15 (saturated), and `stall_count` matches the number of stalled cycles.
  - Without the macro, both counters read 0.
